// File: rtl/keyscan.sv
// 4x4 keypad matrix scanner with full-image debounce and key-press pulse.
// Define KEYSCAN_REPEAT_EN to add auto-repeat pulses on key_press while keys are held.
module keyscan #(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE     = 3,
    parameter int unsigned REPEAT_SCANS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] keys,
    output logic        key_press,
    output logic        scan_tick
);

    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam int unsigned StW  = $clog2(DEBOUNCE + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);
    localparam logic [StW-1:0]  StFull  = StW'(DEBOUNCE);

    if (SCAN_DIV < 4 || DEBOUNCE < 1 || REPEAT_SCANS < 1) begin : g_bad_param
        $error("keyscan: parameter below minimum");
    end

    logic [3:0]      sync1_q, row_sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      col_q, col_d;
    logic [15:0]     raw_q, raw_d;
    logic [15:0]     cand_q, cand_d;
    logic [15:0]     keys_q, keys_d;
    logic [StW-1:0]  stable_q, stable_d;
    logic            press_q, press_d;
    logic            dwell_end;

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        col_d     = col_q;
        raw_d     = raw_q;
        cand_d    = cand_q;
        stable_d  = stable_q;
        keys_d    = keys_q;
        dwell_end = (cnt_q == CntLast);
        scan_tick = dwell_end && (col_q == 2'd3);

        // Sample at the end of the dwell so the pins and synchronizer have settled.
        if (dwell_end) begin
            cnt_d                     = '0;
            col_d                     = col_q + 2'd1;
            raw_d[{col_q, 2'b00} +: 4] = ~row_sync_q;
        end

        // raw_d already holds the column-3 bits, so it is the completed image.
        if (scan_tick) begin
            if (raw_d != cand_q) begin
                cand_d   = raw_d;
                stable_d = StW'(1);
            end else if (stable_q != StFull) begin
                stable_d = stable_q + 1'b1;
            end
            if (stable_d == StFull) begin
                keys_d = cand_d;
            end
        end

        press_d = |(keys_d & ~keys_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 4'hF;
            row_sync_q <= 4'hF;
            cnt_q      <= '0;
            col_q      <= 2'd0;
            raw_q      <= '0;
            cand_q     <= '0;
            stable_q   <= '0;
            keys_q     <= '0;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= row_in;
            row_sync_q <= sync1_q;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            raw_q      <= raw_d;
            cand_q     <= cand_d;
            stable_q   <= stable_d;
            keys_q     <= keys_d;
            press_q    <= press_d;
        end
    end

    assign col_out = ~(4'b0001 << col_q);
    assign keys    = keys_q;

`ifdef KEYSCAN_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_SCANS - 1);

    logic [RepW-1:0] rep_q, rep_d;
    logic            rep_fire;

    // Counts completed scans while keys is nonzero and not about to change.
    always_comb begin
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if ((keys_d != keys_q) || (keys_q == '0)) begin
            rep_d = '0;
        end else if (scan_tick) begin
            if (rep_q == RepLast) begin
                rep_fire = 1'b1;
                rep_d    = '0;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign key_press = press_q | rep_fire;
`else
    assign key_press = press_q;
`endif

endmodule
